// File: rtl/dot_scan_if.sv
// Connection bundle for the dot-matrix row scanner.
// The master side carries enable, brightness and column word; the slave side returns the row/column drive.
interface dot_scan_if #(
   parameter int ROWS = 8
) ();
   logic            en;
   logic [3:0]      bright;
   logic [15:0]     col_in;
   logic [2:0]      row_idx;
   logic [ROWS-1:0] row;
   logic [15:0]     col_out;
   logic            frame_tick;

   modport master (
      output en, bright, col_in,
      input  row_idx, row, col_out, frame_tick
   );

   modport slave (
      input  en, bright, col_in,
      output row_idx, row, col_out, frame_tick
   );
endinterface

// File: rtl/dot_scan.sv
// Row-scan driver for the bicolour 8x8 dot matrix: blanking between rows,
// 4-bit PWM brightness within each row dwell and a pulse on every frame wrap.
module dot_scan #(
   parameter int ROWS    = 8,
   parameter int BLANK   = 2,
   parameter int DWELL_W = 4
) (
   input logic       clk,
   input logic       rst,
   dot_scan_if.slave bus
);
   localparam int                 BW         = $clog2(BLANK);
   localparam logic [BW-1:0]      BLANK_LAST = BW'(BLANK - 1);
   localparam logic [DWELL_W-1:0] DWELL_LAST = '1;
   localparam logic [2:0]         ROW_LAST   = 3'(ROWS - 1);

   typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

   state_t             state;
   logic [BW-1:0]      blank_cnt;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [15:0]        col_reg;
   logic [2:0]         row_idx;
   logic [ROWS-1:0]    row;
   logic [15:0]        col_out;
   logic               frame_tick;

   // PWM compares the top four bits of the dwell position against the level.
   function automatic logic lit(input logic [DWELL_W-1:0] d, input logic [3:0] b);
      return (b == 4'hF) || (d[DWELL_W-1 -: 4] < b);
   endfunction

   function automatic logic [ROWS-1:0] onehot(input logic [2:0] idx);
      return ROWS'(1) << idx;
   endfunction

   // Outputs are loaded with the values belonging to the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         blank_cnt  <= '0;
         dwell_cnt  <= '0;
         col_reg    <= '0;
         row_idx    <= '0;
         row        <= '0;
         col_out    <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= 1'b0;
         if (!bus.en) begin
            state   <= S_IDLE;
            row     <= '0;
            col_out <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  state     <= S_BLANK;
                  blank_cnt <= '0;
                  row       <= '0;
                  col_out   <= '0;
               end
               S_BLANK: begin
                  if (blank_cnt == BLANK_LAST) begin
                     state     <= S_SHOW;
                     dwell_cnt <= '0;
                     col_reg   <= bus.col_in;
                     row       <= onehot(row_idx);
                     col_out   <= lit('0, bus.bright) ? bus.col_in : '0;
                  end else begin
                     blank_cnt <= blank_cnt + 1'b1;
                  end
               end
               S_SHOW: begin
                  if (dwell_cnt == DWELL_LAST) begin
                     state     <= S_BLANK;
                     blank_cnt <= '0;
                     row       <= '0;
                     col_out   <= '0;
                     if (row_idx == ROW_LAST) begin
                        row_idx    <= '0;
                        frame_tick <= 1'b1;
                     end else begin
                        row_idx <= row_idx + 1'b1;
                     end
                  end else begin
                     dwell_cnt <= dwell_cnt + 1'b1;
                     col_out   <= lit(dwell_cnt + 1'b1, bus.bright) ? col_reg : '0;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.row_idx    = row_idx;
   assign bus.row        = row;
   assign bus.col_out    = col_out;
   assign bus.frame_tick = frame_tick;
endmodule

// File: tb/tb_dot_scan.sv
// Bench for dot_scan: vector table for the opening scan, hand sequences for
// frame/abort/sampling corners, then random traffic against a position-based model.
module tb_dot_scan;
   localparam int ROWS  = 8;
   localparam int BLANK = 2;
   localparam int DWELL = 16;
   localparam int ROWP  = BLANK + DWELL;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dot_scan_if #(.ROWS(ROWS)) bus ();
   dot_scan #(.ROWS(ROWS), .BLANK(BLANK), .DWELL_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // Model: a row is a window of ROWP positions, lit region starts at BLANK.
   bit          m_idle = 1'b1;
   int          m_pos  = 0;
   int          m_ridx = 0;
   logic [15:0] m_cap  = '0;
   bit          m_tick = 1'b0;
   logic [7:0]  m_row;
   logic [15:0] m_col;

   typedef struct {
      logic        rst;
      logic        en;
      logic [3:0]  bright;
      logic [15:0] col;
      int          reps;
      logic [7:0]  row;
      logic [15:0] col_out;
      logic [2:0]  ridx;
      logic        tick;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_update(input logic r, input logic e, input logic [3:0] b, input logic [15:0] c);
      m_tick = 1'b0;
      if (r) begin
         m_idle = 1'b1; m_pos = 0; m_ridx = 0; m_cap = '0;
      end else if (!e) begin
         m_idle = 1'b1;
      end else if (m_idle) begin
         m_idle = 1'b0; m_pos = 0;
      end else begin
         m_pos++;
         if (m_pos == BLANK) m_cap = c;
         if (m_pos == ROWP) begin
            m_pos = 0;
            m_ridx = (m_ridx + 1) % ROWS;
            if (m_ridx == 0) m_tick = 1'b1;
         end
      end
      if (!m_idle && m_pos >= BLANK) begin
         m_row = 8'(1 << m_ridx);
         m_col = (b == 4'd15 || ((m_pos - BLANK) * 16 / DWELL) < int'(b)) ? m_cap : 16'h0;
      end else begin
         m_row = '0;
         m_col = '0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update(rst, bus.en, bus.bright, bus.col_in);
      #1;
      check("model_row", 32'(bus.row), 32'(m_row));
      check("model_col", 32'(bus.col_out), 32'(m_col));
      check("model_ridx", 32'(bus.row_idx), 32'(m_ridx));
      check("model_tick", 32'(bus.frame_tick), 32'(m_tick));
   endtask

   task automatic wait_row(input logic [7:0] val, input int bound, input string name);
      int n = 0;
      while (bus.row !== val && n < bound) begin
         step();
         n++;
      end
      if (n >= bound) check(name, 32'(bus.row), 32'(val));
   endtask

   initial begin
      vec_t tbl[$];
      logic [7:0] prev_row;
      logic [2:0] prev_idx;
      int n, nz_col, nz_row;

      tbl.push_back('{1'b1, 1'b1, 4'd15, 16'hA5A5,  2, 8'h00, 16'h0000, 3'd0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 4'd15, 16'hA5A5,  2, 8'h00, 16'h0000, 3'd0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 4'd15, 16'hA5A5, 16, 8'h01, 16'hA5A5, 3'd0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 4'd15, 16'hA5A5,  2, 8'h00, 16'h0000, 3'd1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 4'd15, 16'hA5A5, 16, 8'h02, 16'hA5A5, 3'd1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 4'd4,  16'hA5A5,  2, 8'h00, 16'h0000, 3'd2, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 4'd4,  16'hA5A5,  4, 8'h04, 16'hA5A5, 3'd2, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 4'd4,  16'hA5A5, 12, 8'h04, 16'h0000, 3'd2, 1'b0});

      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].reps; r++) begin
            rst = tbl[i].rst; bus.en = tbl[i].en; bus.bright = tbl[i].bright; bus.col_in = tbl[i].col;
            step();
            check($sformatf("vec%0d_row", i), 32'(bus.row), 32'(tbl[i].row));
            check($sformatf("vec%0d_col", i), 32'(bus.col_out), 32'(tbl[i].col_out));
            check($sformatf("vec%0d_ridx", i), 32'(bus.row_idx), 32'(tbl[i].ridx));
            check($sformatf("vec%0d_tick", i), 32'(bus.frame_tick), 32'(tbl[i].tick));
         end
      end

      // Frame tick: follows the 8'h80 row, then repeats every 144 cycles.
      bus.bright = 4'd15;
      n = 0;
      prev_row = bus.row;
      while (bus.frame_tick !== 1'b1 && n < 300) begin
         prev_row = bus.row;
         step();
         n++;
      end
      check("tick_found", 32'(bus.frame_tick), 32'd1);
      check("tick_prev_row", 32'(prev_row), 32'h80);
      check("tick_ridx", 32'(bus.row_idx), 32'd0);
      n = 0;
      prev_idx = bus.row_idx;
      do begin
         step();
         n++;
         if (bus.row_idx !== prev_idx) begin
            check("ridx_seq", 32'(bus.row_idx), 32'((prev_idx + 3'd1) % ROWS));
            prev_idx = bus.row_idx;
         end
      end while (bus.frame_tick !== 1'b1 && n < 300);
      check("frame_period", 32'(n), 32'd144);

      // Column word is captured only at the start of the row.
      bus.col_in = 16'h00FF;
      wait_row(8'h00, 40, "samp_wait_blank");
      n = 0;
      while (bus.row === 8'h00 && n < 40) begin step(); n++; end
      check("samp_first", 32'(bus.col_out), 32'h00FF);
      for (int i = 0; i < 5; i++) step();
      bus.col_in = 16'hFF00;
      for (int i = 0; i < 10; i++) begin
         step();
         check("samp_hold", 32'(bus.col_out), 32'h00FF);
      end
      step();
      check("samp_row_end", 32'(bus.row), 32'h00);
      n = 0;
      while (bus.row === 8'h00 && n < 40) begin step(); n++; end
      check("samp_next_row", 32'(bus.col_out), 32'hFF00);

      // Abort mid-SHOW on row 3, hold the index, resume with blanking.
      wait_row(8'h08, 300, "abort_wait_row3");
      for (int i = 0; i < 3; i++) step();
      bus.en = 1'b0;
      step();
      check("abort_row", 32'(bus.row), 32'h00);
      check("abort_col", 32'(bus.col_out), 32'h0);
      check("abort_ridx", 32'(bus.row_idx), 32'd3);
      for (int i = 0; i < 3; i++) step();
      check("idle_ridx", 32'(bus.row_idx), 32'd3);
      bus.en = 1'b1;
      step();
      check("resume_blank0", 32'(bus.row), 32'h00);
      step();
      check("resume_blank1", 32'(bus.row), 32'h00);
      step();
      check("resume_row3", 32'(bus.row), 32'h08);

      // Reset in the middle of a SHOW phase.
      for (int i = 0; i < 4; i++) step();
      rst = 1'b1;
      step();
      check("rst_row", 32'(bus.row), 32'h00);
      check("rst_col", 32'(bus.col_out), 32'h0);
      check("rst_ridx", 32'(bus.row_idx), 32'd0);
      check("rst_tick", 32'(bus.frame_tick), 32'd0);
      rst = 1'b0;

      // Brightness 0: row keeps scanning with the columns dark.
      bus.bright = 4'd0;
      bus.col_in = 16'hFFFF;
      nz_col = 0; nz_row = 0;
      for (int i = 0; i < 144; i++) begin
         step();
         if (bus.col_out !== 16'h0) nz_col++;
         if (bus.row !== 8'h00) nz_row++;
      end
      check("dark_col_cycles", 32'(nz_col), 32'd0);
      check("dark_row_cycles", 32'(nz_row), 32'd128);

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         bus.en = ($urandom_range(0, 49) != 0);
         if ($urandom_range(0, 9) == 0) bus.bright = 4'($urandom_range(0, 15));
         bus.col_in = 16'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
